regfile_mp: RTL
===============

Name: regfile_mp

Overview:
- Parametrised successor to the single-write, two-read MIPS register file.
- Adds configurable width, depth and read-port count, plus two write ports with fixed priority and per-byte write enables.
- Optional write-through bypass, optional hardwired-zero register 0, and optional registered read outputs.
- Sits in the decode stage of the pipelined MIPS core. Write port 1 serves writeback; write port 0 serves a second writer (e.g. HI/LO or load return).

Parameters:
DATA_W, 32, data width in bits; must be a multiple of 8
ADDR_W, 5, address width; depth = 2**ADDR_W registers
NRD, 2, number of read ports (1..4)
ZERO_REG, 1, 1 = register 0 reads 0 and ignores writes
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads
READ_REG, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_raddr  in  NRD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
o_rdata  out  NRD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
i_we0  in  1  write enable, port 0
i_waddr0  in  ADDR_W  write address, port 0
i_wdata0  in  DATA_W  write data, port 0
i_wbe0  in  DATA_W/8  byte enables, port 0
i_we1  in  1  write enable, port 1 (priority)
i_waddr1  in  ADDR_W  write address, port 1
i_wdata1  in  DATA_W  write data, port 1
i_wbe1  in  DATA_W/8  byte enables, port 1
o_wr_conflict  out  1  registered flag: previous cycle had both ports writing the same address

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - all registers cleared to 0;
  - o_wr_conflict = 0;
  - if READ_REG = 1, o_rdata = 0.
  - Reset asserted mid-write: the write is lost and the register reads 0.
  - Release is synchronous to the next i_clk edge.
- Write: on rising i_clk, for each port with weN = 1, byte b of reg[waddrN] takes wdataN byte b only where wbeN[b] = 1. Other bytes hold.
- Dual write to same address: merge per byte. Port 1 wins any byte both ports enable; bytes enabled only by port 0 take port 0 data.
- Dual write to different addresses: both writes commit.
- ZERO_REG = 1:
  - writes to address 0 are discarded;
  - reads of address 0 return 0, including on the bypass path;
  - a write to address 0 still counts for o_wr_conflict.
- Read, READ_REG = 0: o_rdata[k] = reg[raddr[k]] combinationally, zero-latency. The value is the pre-edge contents unless bypassed.
- Bypass (BYPASS = 1): if a write port targets raddr[k] this cycle, o_rdata[k] shows the post-write merged value the register will hold after the edge. Priority and byte-merge rules are the same as for the write itself.
- BYPASS = 0: a read sees new data only after the edge.
- Read, READ_REG = 1: o_rdata[k] is registered at the edge and appears one cycle after raddr is presented. It captures the value the combinational path (including bypass) shows in the presenting cycle.
- o_wr_conflict: set on the edge after a cycle with i_we0 & i_we1 & (i_waddr0 == i_waddr1); otherwise cleared on that edge.
- No undefined reads: every address in 0..2**ADDR_W-1 is backed by storage.
- Read ports are independent; any number may address the same register.

Test Plan:
1. Reset: hold i_rst_n = 0 with i_we1 = 1, waddr1 = 3, wdata1 = 0xDEADBEEF across an edge, then release → reg 3 reads 0x00000000, o_wr_conflict = 0.
2. Byte-enable merge: write reg 5 = 0x11223344 (wbe1 = 4'hF), then wbe1 = 4'b0101 with wdata1 = 0xAABBCCDD → reg 5 = 0x11BB33DD.
3. Dual-write collision: we0 = we1 = 1, both to addr 7; wdata0 = 0xFFFFFFFF, wbe0 = 4'hF; wdata1 = 0x00000000, wbe1 = 4'b0011 → reg 7 = 0xFFFF0000; o_wr_conflict = 1 for one cycle, then 0.
4. Bypass, BYPASS = 1, READ_REG = 0: raddr[0] = 11 while writing 0x12345678 to addr 11 → o_rdata[0] = 0x12345678 in the same cycle. With BYPASS = 0 it shows the old value 0 until after the edge.
5. Zero register: write 0xCAFEF00D to addr 0 on both ports → reads of addr 0 return 0 before and after the edge; o_wr_conflict = 1.
6. READ_REG = 1, NRD = 4: sweep raddr 0..31 on all ports after filling reg i = i*0x01010101 → each o_rdata[k] equals the expected value exactly one cycle after its address is presented.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port register file for the decode stage of the pipelined MIPS core.
// Two write ports (port 1 has priority per byte), NRD read ports, optional
// write-through bypass, hardwired-zero register 0 and registered read data.
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int READ_REG = 0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NRD*ADDR_W-1:0]   i_raddr,
    output logic [NRD*DATA_W-1:0]   o_rdata,
    input  logic                    i_we0,
    input  logic [ADDR_W-1:0]       i_waddr0,
    input  logic [DATA_W-1:0]       i_wdata0,
    input  logic [DATA_W/8-1:0]     i_wbe0,
    input  logic                    i_we1,
    input  logic [ADDR_W-1:0]       i_waddr1,
    input  logic [DATA_W-1:0]       i_wdata1,
    input  logic [DATA_W/8-1:0]     i_wbe1,
    output logic                    o_wr_conflict
);

    localparam int DEPTH  = 1 << ADDR_W;
    localparam int NBYTES = DATA_W / 8;

    logic [DATA_W-1:0]     mem [DEPTH];
    logic                  wr0_en;
    logic                  wr1_en;
    logic [NRD*DATA_W-1:0] comb_rdata;
    logic [ADDR_W-1:0]     rd_addr;
    logic [DATA_W-1:0]     rd_word;

    // Writes to register 0 are dropped when it is hardwired to zero.
    assign wr0_en = i_we0 && !((ZERO_REG != 0) && (i_waddr0 == '0));
    assign wr1_en = i_we1 && !((ZERO_REG != 0) && (i_waddr1 == '0));

    // Byte-masked storage update; port 1 is applied last so it wins shared bytes.
    // NOTE: the array is built from flops, so it can and must be cleared by the async reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int b = 0; b < NBYTES; b++) begin
                if (wr0_en && i_wbe0[b]) begin
                    mem[i_waddr0][b*8 +: 8] <= i_wdata0[b*8 +: 8];
                end
            end
            // NOTE: with non-blocking assignments the last one to the same bits wins, giving port 1 priority.
            for (int b = 0; b < NBYTES; b++) begin
                if (wr1_en && i_wbe1[b]) begin
                    mem[i_waddr1][b*8 +: 8] <= i_wdata1[b*8 +: 8];
                end
            end
        end
    end

    // Combinational read with optional same-cycle forwarding of the merged write value.
    always_comb begin
        // NOTE: every variable gets a default up front so no latch can be inferred.
        comb_rdata = '0;
        rd_addr    = '0;
        rd_word    = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_addr = i_raddr[k*ADDR_W +: ADDR_W];
            rd_word = mem[rd_addr];
            if (BYPASS != 0) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (i_we1 && (i_waddr1 == rd_addr) && i_wbe1[b]) begin
                        rd_word[b*8 +: 8] = i_wdata1[b*8 +: 8];
                    end else if (i_we0 && (i_waddr0 == rd_addr) && i_wbe0[b]) begin
                        rd_word[b*8 +: 8] = i_wdata0[b*8 +: 8];
                    end
                end
            end
            if ((ZERO_REG != 0) && (rd_addr == '0)) begin
                rd_word = '0;
            end
            comb_rdata[k*DATA_W +: DATA_W] = rd_word;
        end
    end

    generate
        if (READ_REG != 0) begin : g_rreg
            logic [NRD*DATA_W-1:0] rdata_q;

            // Capture whatever the combinational path shows, one cycle of latency.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    rdata_q <= '0;
                end else begin
                    rdata_q <= comb_rdata;
                end
            end

            assign o_rdata = rdata_q;
        end else begin : g_rcomb
            assign o_rdata = comb_rdata;
        end
    endgenerate

    // Flag a same-address dual write on the following cycle (counts even for address 0).
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wr_conflict <= 1'b0;
        end else begin
            o_wr_conflict <= i_we0 && i_we1 && (i_waddr0 == i_waddr1);
        end
    end

endmodule
